// File: rtl/fft_pkg.sv
// Shared FFT types and helpers: sample width, complex payload, write FSM states, bit reversal.
package fft_pkg;

  localparam int unsigned DW        = 16;
  localparam int unsigned LOG2N_DEF = 4;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } wr_state_t;

  // Reverses the low 'width' bits of x; upper bits of the result are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] x, input int unsigned width);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < width; i++) begin
      r[5'(i)] = x[5'(width - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream bundle for the bit-reversal reorder block.
// FFT_REORDER_BYPASS_EN adds the per-frame bypass request.
interface fft_bitrev_reorder_if
  import fft_pkg::*;
  #(parameter int unsigned LOG2N = LOG2N_DEF) ();

  logic                 en;
  logic signed [DW-1:0] in_re;
  logic signed [DW-1:0] in_im;
  logic                 in_sop;
  logic signed [DW-1:0] out_re;
  logic signed [DW-1:0] out_im;
  logic                 out_valid;
  logic                 out_sop;
  logic [LOG2N-1:0]     out_idx;
  logic                 err_sync;
`ifdef FFT_REORDER_BYPASS_EN
  logic                 bypass;

  modport master (output en, in_re, in_im, in_sop, bypass,
                  input  out_re, out_im, out_valid, out_sop, out_idx, err_sync);
  modport slave  (input  en, in_re, in_im, in_sop, bypass,
                  output out_re, out_im, out_valid, out_sop, out_idx, err_sync);
`else
  modport master (output en, in_re, in_im, in_sop,
                  input  out_re, out_im, out_valid, out_sop, out_idx, err_sync);
  modport slave  (input  en, in_re, in_im, in_sop,
                  output out_re, out_im, out_valid, out_sop, out_idx, err_sync);
`endif

endinterface

// File: rtl/fft_reorder_dpram.sv
// Simple dual-port RAM: one write port, one registered read port; address MSB selects the bank.
module fft_reorder_dpram #(
  parameter int unsigned AW = 5,
  parameter int unsigned W  = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT frames into natural order through a ping-pong buffer.
// FFT_REORDER_BYPASS_EN: optional per-frame bypass keeping the input order.
module fft_bitrev_reorder
  import fft_pkg::*;
  #(parameter int unsigned LOG2N = LOG2N_DEF) (
  input logic                clk,
  input logic                rst,
  fft_bitrev_reorder_if.slave bus
);

  localparam int unsigned N  = 1 << LOG2N;
  localparam int unsigned AW = LOG2N + 1;
  localparam int unsigned W  = 2 * DW;

  wr_state_t        state, state_nxt;
  logic [LOG2N-1:0] wcnt, wcnt_nxt;
  logic             wbank, wbank_nxt;
  logic             we_c, launch_c, resync_c;
  logic [LOG2N-1:0] waddr_lo;

  logic             rd_active;
  logic [LOG2N-1:0] rcnt;
  logic             rbank;
  logic [LOG2N-1:0] rd_lo;
  logic             rd_v;
  logic [LOG2N-1:0] rd_idx;

  cplx_t            wr_word, rd_word;

  assign wr_word.re = bus.in_re;
  assign wr_word.im = bus.in_im;

  // Write-side FSM: state register
  always_ff @(posedge clk) begin
    if (rst)         state <= ST_IDLE;
    else if (bus.en) state <= state_nxt;
  end

  // Write-side FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.in_sop) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Write-side FSM: write strobe, address, counters, frame launch and resync
  always_comb begin
    we_c      = 1'b0;
    waddr_lo  = '0;
    wcnt_nxt  = wcnt;
    wbank_nxt = wbank;
    launch_c  = 1'b0;
    resync_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.in_sop) begin
          we_c     = 1'b1;
          wcnt_nxt = LOG2N'(1);
        end
      end
      ST_RUN: begin
        we_c = 1'b1;
        if (bus.in_sop && (wcnt != '0)) begin
          resync_c = 1'b1;
          wcnt_nxt = LOG2N'(1);
        end else begin
          waddr_lo = LOG2N'(bitrev(32'(wcnt), LOG2N));
          wcnt_nxt = wcnt + LOG2N'(1);
          if (wcnt == LOG2N'(N - 1)) begin
            wbank_nxt = ~wbank;
            launch_c  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt         <= '0;
      wbank        <= 1'b0;
      bus.err_sync <= 1'b0;
    end else if (bus.en) begin
      wcnt         <= wcnt_nxt;
      wbank        <= wbank_nxt;
      bus.err_sync <= resync_c;
    end
  end

  // Read sequencer: N natural-order reads of the bank just completed
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_active <= 1'b0;
      rcnt      <= '0;
      rbank     <= 1'b0;
      rd_v      <= 1'b0;
      rd_idx    <= '0;
    end else if (bus.en) begin
      rd_v <= rd_active;
      if (rd_active) rd_idx <= rcnt;
      if (launch_c) begin
        rd_active <= 1'b1;
        rcnt      <= '0;
        rbank     <= wbank;
      end else if (rd_active) begin
        rcnt <= rcnt + LOG2N'(1);
        if (rcnt == LOG2N'(N - 1)) rd_active <= 1'b0;
      end
    end
  end

`ifdef FFT_REORDER_BYPASS_EN
  logic bypass_q;

  always_ff @(posedge clk) begin
    if (rst)                      bypass_q <= 1'b0;
    else if (bus.en && launch_c)  bypass_q <= bus.bypass;
  end

  assign rd_lo = bypass_q ? LOG2N'(bitrev(32'(rcnt), LOG2N)) : rcnt;
`else
  assign rd_lo = rcnt;
`endif

  fft_reorder_dpram #(.AW(AW), .W(W)) u_ram (
    .clk   (clk),
    .we    (bus.en & we_c),
    .waddr ({wbank, waddr_lo}),
    .wdata (wr_word),
    .re    (bus.en & rd_active),
    .raddr ({rbank, rd_lo}),
    .rdata (rd_word)
  );

  // Output register; data and index hold while no sample is valid
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_re    <= '0;
      bus.out_im    <= '0;
      bus.out_valid <= 1'b0;
      bus.out_sop   <= 1'b0;
      bus.out_idx   <= '0;
    end else if (bus.en) begin
      bus.out_valid <= rd_v;
      bus.out_sop   <= rd_v && (rd_idx == '0);
      if (rd_v) begin
        bus.out_re  <= rd_word.re;
        bus.out_im  <= rd_word.im;
        bus.out_idx <= rd_idx;
      end
    end
  end

endmodule
